lenet_image_loader: RTL and testbench

- Front-end stage directly upstream of the LeNet top.
- Accepts a raster stream of 28x28 8-bit grayscale pixels over a valid/ready handshake.
- Converts each pixel to IEEE-754 single precision, scaled as v/256, and places it in a zero-padded 32x32 frame buffer driving the CNN image input.
- Pulses start once the frame is complete, then holds the frame stable until the CNN reports completion.

---
 rtl/lenet_image_loader_pkg.sv | 19 +
 rtl/lenet_image_loader_if.sv | 25 ++
 rtl/lenet_image_loader_u8_to_fp32.sv | 27 ++
 rtl/lenet_image_loader.sv | 97 +++++++++
 tb/tb_lenet_image_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_image_loader_pkg.sv
// Shared constants and types for the LeNet image loader front-end.
// Provides frame geometry, the fp32 word type and the loader FSM states.
package lenet_pkg;

    localparam int IMG_IN  = 28;
    localparam int IMG_OUT = 32;
    localparam int PIX_W   = 8;
    localparam int FP_W    = 32;
    localparam int PAD     = (IMG_OUT - IMG_IN) / 2;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT
    } loader_state_t;

endpackage

// File: rtl/lenet_image_loader_if.sv
// Pixel stream handshake between the image source and the loader.
// Master drives pixel/valid/sof, slave answers with ready.
interface lenet_image_loader_if;
    import lenet_pkg::*;

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_sof;
    logic             pix_ready;

    modport master (
        output pix_in,
        output pix_valid,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        input  pix_sof,
        output pix_ready
    );

endinterface

// File: rtl/lenet_image_loader_u8_to_fp32.sv
// Exact unsigned-pixel to IEEE-754 single conversion of v/2^PIX_W.
// Priority encoder finds the MSB, a left shift builds the mantissa.
module u8_to_fp32
    import lenet_pkg::*;
(
    input  logic [PIX_W-1:0] v,
    output fp32_t            f
);

    localparam int PW = $clog2(PIX_W);

    logic [PW-1:0] p;
    logic [31:0]   sh;
    logic [7:0]    e;

    // MSB search, normalising shift and exponent bias
    always_comb begin
        p = '0;
        for (int i = 0; i < PIX_W; i++) begin
            if (v[i]) p = PW'(i);
        end
        sh = 32'(v) << (5'd23 - 5'(p));
        e  = 8'(127 - PIX_W) + 8'(p);
        f  = (v == '0) ? '0 : {1'b0, e, sh[22:0]};
    end

endmodule

// File: rtl/lenet_image_loader.sv
// Pixel stream to zero-padded fp32 frame buffer feeding the LeNet core.
// Define LOADER_INVERT_EN to invert pixels (black-on-white sources).
module lenet_image_loader
    import lenet_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    lenet_image_loader_if.slave                   pix,
    input  logic                                  cnn_done,
    output fp32_t [IMG_OUT-1:0][IMG_OUT-1:0]      image_out,
    output logic                                  start,
    output logic                                  busy
);

    localparam logic [4:0] LAST = 5'(IMG_IN - 1);
    localparam logic [4:0] OFS  = 5'(PAD);

    loader_state_t    state;
    logic [4:0]       row;
    logic [4:0]       col;
    logic             ready;
    logic [PIX_W-1:0] v;
    fp32_t            f;
    logic [4:0]       r;
    logic [4:0]       c;
    logic             xfer;
    logic             last;

    assign pix.pix_ready = ready;
    assign xfer          = pix.pix_valid && ready;

`ifdef LOADER_INVERT_EN
    assign v = ~pix.pix_in;
`else
    assign v = pix.pix_in;
`endif

    u8_to_fp32 u_cvt (
        .v (v),
        .f (f)
    );

    // Write position: SOF forces the frame origin for resync
    always_comb begin
        r    = pix.pix_sof ? 5'd0 : row;
        c    = pix.pix_sof ? 5'd0 : col;
        last = (r == LAST) && (c == LAST);
    end

    // Loader FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            row       <= '0;
            col       <= '0;
            image_out <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            start <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        image_out[r + OFS][c + OFS] <= f;
                        if (last) begin
                            state <= FIRE;
                            ready <= 1'b0;
                            start <= 1'b1;
                            row   <= '0;
                            col   <= '0;
                        end else if (c == LAST) begin
                            row <= r + 5'd1;
                            col <= '0;
                        end else begin
                            row <= r;
                            col <= c + 5'd1;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT;
                    busy  <= 1'b1;
                end
                WAIT: begin
                    if (cnn_done) begin
                        state <= LOAD;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_image_loader.sv
// Self-checking bench for lenet_image_loader: vector table plus scoreboard.
// Honours LOADER_INVERT_EN when the design is built with it.
module tb_lenet_image_loader;
    import lenet_pkg::*;

    logic  clk      = 1'b0;
    logic  reset    = 1'b1;
    logic  cnn_done = 1'b0;
    fp32_t [IMG_OUT-1:0][IMG_OUT-1:0] image_out;
    logic  start;
    logic  busy;

    lenet_image_loader_if pif ();

    lenet_image_loader dut (
        .clk       (clk),
        .reset     (reset),
        .pix       (pif),
        .cnn_done  (cnn_done),
        .image_out (image_out),
        .start     (start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference conversion: normalise by repeated left shift
    function automatic fp32_t model(logic [7:0] raw);
        logic [7:0] m;
        int s;
`ifdef LOADER_INVERT_EN
        m = 8'hFF - raw;
`else
        m = raw;
`endif
        if (m == 8'h00) return 32'h0;
        s = 0;
        while (!m[7]) begin
            m = m << 1;
            s++;
        end
        return {1'b0, 8'(126 - s), m[6:0], 16'h0};
    endfunction

    typedef struct {
        int    r;
        int    c;
        fp32_t w;
    } sb_t;

    sb_t   q[$];
    fp32_t exp_img[IMG_OUT][IMG_OUT];
    int    mr;
    int    mc;

    // Frame model and scoreboard: push on transfer, pop just after the edge
    always begin
        sb_t e;
        fp32_t w;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < IMG_OUT; i++)
                for (int j = 0; j < IMG_OUT; j++)
                    exp_img[i][j] = 32'h0;
            mr = 0;
            mc = 0;
            q.delete();
        end else if (pif.pix_valid && pif.pix_ready) begin
            if (pif.pix_sof) begin
                mr = 0;
                mc = 0;
            end
            w = model(pif.pix_in);
            exp_img[mr+PAD][mc+PAD] = w;
            q.push_back('{mr, mc, w});
            if (mc == IMG_IN - 1) begin
                mc = 0;
                mr = (mr == IMG_IN - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("sb_r%0d_c%0d", e.r, e.c),
                image_out[e.r+PAD][e.c+PAD], e.w);
        end
    end

    // Count start pulses
    always @(negedge clk) if (start) starts++;

    task automatic frame_check(string name);
        int m = 0;
        for (int i = 0; i < IMG_OUT; i++)
            for (int j = 0; j < IMG_OUT; j++)
                if (image_out[i][j] !== exp_img[i][j]) m++;
        chk(name, m, 0);
    endtask

    task automatic send(logic [7:0] v, logic sof);
        bit ok = 0;
        pif.pix_in    = v;
        pif.pix_valid = 1'b1;
        pif.pix_sof   = sof;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (pif.pix_ready) begin
                ok = 1;
                break;
            end
        end
        #1;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic stream(int n, logic [7:0] v);
        for (int i = 0; i < n; i++) send(v, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        fp32_t      want;
        fp32_t      want_inv;
    } vec_t;

    vec_t  tv[5];
    int    sc0;
    int    err;
    fp32_t w80;

    initial begin
        tv[0] = '{8'h01, 1'b1, 32'h3B800000, 32'h3F7E0000};
        tv[1] = '{8'hFF, 1'b0, 32'h3F7F0000, 32'h00000000};
        tv[2] = '{8'h00, 1'b0, 32'h00000000, 32'h3F7F0000};
        tv[3] = '{8'h80, 1'b0, 32'h3F000000, 32'h3EFE0000};
        tv[4] = '{8'h40, 1'b0, 32'h3E800000, 32'h3F3F0000};
`ifdef LOADER_INVERT_EN
        w80 = 32'h3EFE0000;
`else
        w80 = 32'h3F000000;
`endif
        pif.pix_in    = '0;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", pif.pix_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        frame_check("rst_frame");
        reset = 1'b0;

        sc0 = starts;
        for (int i = 0; i < 5; i++) begin
            send(tv[i].pix, tv[i].sof);
`ifdef LOADER_INVERT_EN
            chk($sformatf("vec%0d", i), image_out[PAD][PAD+i], tv[i].want_inv);
`else
            chk($sformatf("vec%0d", i), image_out[PAD][PAD+i], tv[i].want);
`endif
        end
        stream(778, 8'h80);
        chk("no_early_start", start, 0);
        send(8'h80, 1'b0);
        chk("start_latency", start, 1);
        chk("fire_ready", pif.pix_ready, 0);
        tick();
        chk("start_one_cycle", start, 0);
        chk("wait_busy", busy, 1);
        chk("one_start", starts - sc0, 1);
        chk("last_pix", image_out[PAD+IMG_IN-1][PAD+IMG_IN-1], w80);
        chk("corner_tl", image_out[0][0], 0);
        chk("corner_br", image_out[IMG_OUT-1][IMG_OUT-1], 0);
        frame_check("frame1");

        pif.pix_in    = 8'h11;
        pif.pix_valid = 1'b1;
        err = 0;
        repeat (50) begin
            tick();
            if (pif.pix_ready !== 1'b0 || busy !== 1'b1) err++;
        end
        pif.pix_valid = 1'b0;
        chk("wait_hold", err, 0);
        frame_check("wait_frozen");
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        chk("done_busy", busy, 0);
        chk("done_ready", pif.pix_ready, 1);
        send(8'h01, 1'b0);
        chk("next_frame_px0", image_out[PAD][PAD], model(8'h01));

        stream(100, 8'h10);
        send(8'h40, 1'b1);
        chk("sof_pix", image_out[PAD][PAD], model(8'h40));
        sc0 = starts;
        stream(782, 8'h20);
        chk("resync_no_start", starts - sc0, 0);
        send(8'h20, 1'b0);
        chk("resync_start", start, 1);
        frame_check("frame2");

        tick();
        chk("in_wait", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_ready", pif.pix_ready, 1);
        chk("rstw_busy", busy, 0);
        chk("rstw_start", start, 0);
        frame_check("rstw_frame");

        sc0 = starts;
        stream(400, 8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstm_ready", pif.pix_ready, 1);
        chk("rstm_busy", busy, 0);
        frame_check("rstm_frame");
        repeat (3) tick();
        chk("rstm_no_start", starts - sc0, 0);

        send(8'h80, 1'b0);
        chk("post_rst_px0", image_out[PAD][PAD], w80);
        send(8'h01, 1'b0);
        pif.pix_sof = 1'b1;
        cnn_done    = 1'b1;
        tick();
        pif.pix_sof = 1'b0;
        cnn_done    = 1'b0;
        chk("load_done_ignored", busy, 0);
        chk("load_ready_kept", pif.pix_ready, 1);
        send(8'h40, 1'b0);
        chk("sof_no_valid", image_out[PAD][PAD+2], model(8'h40));
        frame_check("final_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
